// File: rtl/vt1_seq_ctrl_if.sv
// Handshake bundle between the filter sequencer and the datapath/host side.
// The master modport is the sequencer; the slave modport is the datapath,
// SRAM and host logic that answer it.
interface vt1_seq_ctrl_if #(
  parameter int ADDR_W = 8
);

  // Host request/abort and datapath completion strobes
  logic              start;
  logic              abort;
  logic              xload_done;
  logic              ALU_done;
  logic              ry;

  // Sequencer-driven enables, SRAM control and host status
  logic              input_load_en;
  logic              ALU_en;
  logic              cs_n;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, abort, xload_done, ALU_done, ry,
    output input_load_en, ALU_en, cs_n, rd_addr, rd_valid, busy, done, err
  );

  modport slave (
    output start, abort, xload_done, ALU_done, ry,
    input  input_load_en, ALU_en, cs_n, rd_addr, rd_valid, busy, done, err
  );

endinterface

// File: rtl/vt1_seq_ctrl.sv
// Frame sequencer for the filter datapath: X_buffer load, ALU compute and
// writeback, then SRAM readout of N_RESULTS words. Each waiting phase has a
// timeout; abort returns to IDLE without flagging an error. All outputs are
// registered and are computed from the next state, so an output change lands
// on the same edge as the state change that causes it.
module vt1_seq_ctrl #(
  parameter int N_RESULTS = 32,
  parameter int ADDR_W    = 8,
  parameter int TO_W      = 12
) (
  input  logic           clk,
  input  logic           rst,
  vt1_seq_ctrl_if.master seq_if
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_WAIT = 3'd4,
    S_DONE    = 3'd5,
    S_ERR     = 3'd6
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_RESULTS - 1);
  // A phase gives up on the cycle in which the counter would reach
  // all-ones, so a waiting state lasts at most 2^TO_W-1 cycles.
  localparam logic [TO_W-1:0]   TC_LIMIT  = {{(TO_W-1){1'b1}}, 1'b0};
  localparam logic [TO_W-1:0]   TC_ONE    = {{(TO_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [TO_W-1:0]   tc_q, tc_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              err_q, err_d;
  logic              rd_valid_q, rd_valid_d;
  logic              load_en_q;
  logic              alu_en_q;
  logic              cs_n_q;
  logic              busy_q;
  logic              done_q;
  logic              timeout_s;

  assign timeout_s = (tc_q == TC_LIMIT);

  // Next state, read address, error flag and read-valid strobe
  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    err_d      = err_q;
    rd_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (seq_if.start) begin
          state_d = S_LOAD;
          err_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        // completion beats a timeout seen in the same cycle
        if (seq_if.xload_done) begin
          state_d = S_COMPUTE;
        end else if (timeout_s) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_COMPUTE: begin
        if (seq_if.ALU_done) begin
          state_d   = S_RD_REQ;
          rd_addr_d = '0;
        end else if (timeout_s) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          state_d = S_COMPUTE;
        end
      end
      S_RD_REQ: begin
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (seq_if.ry) begin
          rd_valid_d = 1'b1;
          if (rd_addr_q == LAST_ADDR) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_RD_REQ;
            rd_addr_d = rd_addr_q + ADDR_ONE;
          end
        end else if (timeout_s) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          state_d = S_RD_WAIT;
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        rd_addr_d = '0;
      end
      S_ERR: begin
        state_d   = S_IDLE;
        rd_addr_d = '0;
      end
      default: begin
        state_d   = S_IDLE;
        rd_addr_d = '0;
      end
    endcase
    // abort overrides everything, including a same-cycle timeout, and
    // leaves the error flag untouched
    if (seq_if.abort) begin
      state_d    = S_IDLE;
      rd_addr_d  = '0;
      err_d      = err_q;
      rd_valid_d = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // Phase timeout counter: cleared on any state change, runs only while waiting
  always_comb begin
    tc_d = '0;
    if (state_d != state_q) begin
      tc_d = '0;
    end else if ((state_q == S_LOAD) || (state_q == S_COMPUTE) || (state_q == S_RD_WAIT)) begin
      tc_d = tc_q + TC_ONE;
    end else begin
      tc_d = '0;
    end
  end

  // State, counter and registered outputs; reset forces cs_n high at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      tc_q       <= '0;
      rd_addr_q  <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      load_en_q  <= 1'b0;
      alu_en_q   <= 1'b0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tc_q       <= tc_d;
      rd_addr_q  <= rd_addr_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      load_en_q  <= (state_d == S_LOAD);
      alu_en_q   <= (state_d == S_COMPUTE) && (state_q != S_COMPUTE);
      cs_n_q     <= (state_d != S_RD_REQ);
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_DONE);
    end
  end

  assign seq_if.input_load_en = load_en_q;
  assign seq_if.ALU_en        = alu_en_q;
  assign seq_if.cs_n          = cs_n_q;
  assign seq_if.rd_addr       = rd_addr_q;
  assign seq_if.rd_valid      = rd_valid_q;
  assign seq_if.busy          = busy_q;
  assign seq_if.done          = done_q;
  assign seq_if.err           = err_q;

endmodule

// File: tb/tb_vt1_seq_ctrl.sv
// Directed bench for vt1_seq_ctrl. u0: N_RESULTS=4, TO_W=6 (nominal frame,
// abort in RD_WAIT, reset mid-LOAD). u1: N_RESULTS=1, TO_W=4 (load timeout,
// cycle-by-cycle vector table, abort racing a timeout).
module tb_vt1_seq_ctrl;

  localparam int AW = 8;
  // output vector: {load_en, ALU_en, cs_n, rd_addr[7:0], rd_valid, busy, done, err}
  localparam logic [14:0] RST_V = 15'b0_0_1_00000000_0_0_0_0;

  logic clk;
  logic rst0;
  logic rst1;
  int   n_checks;
  int   n_errors;

  vt1_seq_ctrl_if #(.ADDR_W(AW)) if0 ();
  vt1_seq_ctrl_if #(.ADDR_W(AW)) if1 ();

  vt1_seq_ctrl #(.N_RESULTS(4), .ADDR_W(AW), .TO_W(6)) u0 (
    .clk(clk), .rst(rst0), .seq_if(if0)
  );
  vt1_seq_ctrl #(.N_RESULTS(1), .ADDR_W(AW), .TO_W(4)) u1 (
    .clk(clk), .rst(rst1), .seq_if(if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  in_v;   // {start, abort, xload_done, ALU_done, ry}
    logic [14:0] exp_v;  // outputs after the clock edge
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] outs0();
    return {if0.input_load_en, if0.ALU_en, if0.cs_n, if0.rd_addr,
            if0.rd_valid, if0.busy, if0.done, if0.err};
  endfunction

  function automatic logic [14:0] outs1();
    return {if1.input_load_en, if1.ALU_en, if1.cs_n, if1.rd_addr,
            if1.rd_valid, if1.busy, if1.done, if1.err};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int load_cnt, alu_en_cnt, alu_cnt, valid_cnt, done_cnt, ry_at, post, lcnt, alu_seen, dcnt;
    logic computing, finished, prev_csn_low, aborted, pre_le;
    int cs_addrs[$];

    n_checks = 0;
    n_errors = 0;
    {if0.start, if0.abort, if0.xload_done, if0.ALU_done, if0.ry} = 5'b0;
    {if1.start, if1.abort, if1.xload_done, if1.ALU_done, if1.ry} = 5'b0;
    rst0 = 1'b0;
    rst1 = 1'b0;

    // vector table for u1 (single-word readout)
    tbl[0] = '{5'b10000, 15'b1_0_1_00000000_0_1_0_0}; // start -> LOAD, err cleared
    tbl[1] = '{5'b00110, 15'b0_1_1_00000000_0_1_0_0}; // xload_done -> COMPUTE, ALU_done in LOAD ignored
    tbl[2] = '{5'b00010, 15'b0_0_0_00000000_0_1_0_0}; // ALU_done alongside ALU_en -> RD_REQ
    tbl[3] = '{5'b00001, 15'b0_0_1_00000000_0_1_0_0}; // RD_WAIT, ry in RD_REQ has no effect
    tbl[4] = '{5'b00001, 15'b0_0_1_00000000_1_1_1_0}; // ry -> DONE with rd_valid
    tbl[5] = '{5'b10000, 15'b0_0_1_00000000_0_0_0_0}; // start on done cycle ignored -> IDLE
    tbl[6] = '{5'b00000, 15'b0_0_1_00000000_0_0_0_0}; // not queued: stays IDLE

    repeat (2) @(posedge clk);
    #1;
    check("reset_u0", int'(outs0()), int'(RST_V));
    check("reset_u1", int'(outs1()), int'(RST_V));
    rst0 = 1'b1;
    rst1 = 1'b1;
    tick();

    // ---------------- nominal frame on u0 ----------------
    load_cnt = 0; alu_en_cnt = 0; alu_cnt = 0; valid_cnt = 0; done_cnt = 0;
    ry_at = -1; post = 0; computing = 1'b0; finished = 1'b0;
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (if0.input_load_en) load_cnt++;
      if (if0.ALU_en) begin
        alu_en_cnt++;
        computing = 1'b1;
        alu_cnt = 0;
      end
      if (computing) alu_cnt++;
      if (!if0.cs_n) begin
        cs_addrs.push_back(int'(if0.rd_addr));
        ry_at = cyc + 2;
      end
      if (if0.rd_valid) valid_cnt++;
      if (if0.done) done_cnt++;
      if0.xload_done = if0.input_load_en && (load_cnt == 10);
      if0.ALU_done   = computing && (alu_cnt == 20);
      if0.ry         = (cyc == ry_at);
      if0.start      = (computing && (alu_cnt == 5)) || if0.done;
      if (computing && (alu_cnt == 20)) computing = 1'b0;
      if ((done_cnt > 0) && !if0.done) post++;
      if (post == 4) begin
        finished = 1'b1;
        break;
      end
      tick();
    end
    {if0.start, if0.xload_done, if0.ALU_done, if0.ry} = 4'b0;
    check("nom_finished", int'(finished), 1);
    check("nom_load_cycles", load_cnt, 10);
    check("nom_alu_en_cycles", alu_en_cnt, 1);
    check("nom_cs_count", cs_addrs.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("nom_cs_addr%0d", i), (i < cs_addrs.size()) ? cs_addrs[i] : -1, i);
    check("nom_rd_valid", valid_cnt, 4);
    check("nom_done_pulses", done_cnt, 1);
    check("nom_idle_after", int'({if0.busy, if0.err, if0.cs_n}), 1);

    // ---------------- load timeout on u1 ----------------
    lcnt = 0; alu_seen = 0;
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (if1.ALU_en) alu_seen++;
      if (!if1.input_load_en) break;
      lcnt++;
      tick();
    end
    check("to_load_cycles", lcnt, 15);
    check("to_err_set", int'(if1.err), 1);
    check("to_no_alu_en", alu_seen + int'(if1.ALU_en), 0);
    tick();
    check("to_idle_err_held", int'({if1.busy, if1.err}), 1);

    // ---------------- vector table on u1 (restart clears err) ----------------
    for (int i = 0; i < 7; i++) begin
      {if1.start, if1.abort, if1.xload_done, if1.ALU_done, if1.ry} = tbl[i].in_v;
      tick();
      check($sformatf("vec%0d", i), int'(outs1()), int'(tbl[i].exp_v));
    end
    {if1.start, if1.abort, if1.xload_done, if1.ALU_done, if1.ry} = 5'b0;

    // ---------------- abort in the timeout cycle on u1 ----------------
    lcnt = 0;
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (if1.input_load_en) lcnt++;
      else break;
      if (lcnt == 15) begin
        if1.abort = 1'b1;
        tick();
        if1.abort = 1'b0;
        break;
      end
      tick();
    end
    check("abt_to_reached", lcnt, 15);
    check("abt_to_outs", int'({if1.input_load_en, if1.busy, if1.err}), 0);
    tick();
    check("abt_to_err_clear", int'({if1.busy, if1.err}), 0);

    // ---------------- abort in RD_WAIT at rd_addr=2 on u0 ----------------
    prev_csn_low = 1'b0; aborted = 1'b0;
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if0.xload_done = if0.input_load_en;
      if0.ALU_done   = if0.ALU_en;
      if0.ry         = 1'b1;
      if0.abort      = prev_csn_low && (if0.rd_addr == 8'd2);
      prev_csn_low   = !if0.cs_n;
      tick();
      if (if0.abort) begin
        aborted = 1'b1;
        break;
      end
    end
    {if0.abort, if0.xload_done, if0.ALU_done, if0.ry} = 4'b0;
    check("abt_rd_hit", int'(aborted), 1);
    check("abt_rd_outs", int'(outs0()), int'(RST_V));
    dcnt = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (if0.done || if0.busy) dcnt++;
    end
    check("abt_rd_quiet", dcnt, 0);

    // ---------------- asynchronous reset mid-LOAD on u0 ----------------
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    tick();
    tick();
    pre_le = if0.input_load_en;
    check("rst_mid_pre_load", int'(pre_le), 1);
    #3;
    rst0 = 1'b0;
    #1;
    check("rst_mid_immediate", int'({if0.input_load_en, if0.busy, if0.cs_n}), 1);
    tick();
    rst0 = 1'b1;
    tick();
    tick();
    check("rst_mid_idle_after", int'(outs0()), int'(RST_V));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
